// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order instruction-memory requests and
// queues returned words for decode, with redirect flush and in-flight response discard.
module instr_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ReqValid,
   output logic [31:0] ReqAddr,
   input  logic        ReqReady,
   input  logic        RespValid,
   input  logic [31:0] RespData,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]      fetch_pc, fetch_pc_n;
   logic [31:0]      pc_q    [DEPTH];
   logic [31:0]      pc_n    [DEPTH];
   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      instr_n [DEPTH];
   logic [DEPTH-1:0] filled_q, filled_n;
   logic [PW-1:0]    head, head_n, tail, tail_n, fill_ptr, fill_n;
   logic [CW-1:0]    alloc, alloc_n, pending, pending_n, discard, discard_n;
   logic             fire, resp, xfer;

   // Next-state: fire, response and transfer first, redirect applied last
   always_comb begin
      fire       = ReqValid && ReqReady;
      resp       = RespValid && (pending != '0);
      xfer       = InstrValid && InstrReady;
      fetch_pc_n = fetch_pc;
      pc_n       = pc_q;
      instr_n    = instr_q;
      filled_n   = filled_q;
      head_n     = head;
      tail_n     = tail;
      fill_n     = fill_ptr;
      discard_n  = discard;
      alloc_n    = alloc + CW'(fire) - CW'(xfer);
      pending_n  = pending + CW'(fire) - CW'(resp);

      if (fire) begin
         pc_n[tail]     = fetch_pc;
         filled_n[tail] = 1'b0;
         tail_n         = tail + PW'(1);
         fetch_pc_n     = fetch_pc + 32'd4;
      end

      // Responses return in order, so the oldest unfilled entry is always fill_ptr
      if (resp) begin
         if (discard != '0) begin
            discard_n = discard - CW'(1);
         end else begin
            instr_n[fill_ptr]  = RespData;
            filled_n[fill_ptr] = 1'b1;
            fill_n             = fill_ptr + PW'(1);
         end
      end

      if (xfer) begin
         filled_n[head] = 1'b0;
         head_n         = head + PW'(1);
      end

      if (Redirect) begin
         filled_n   = '0;
         head_n     = '0;
         tail_n     = '0;
         fill_n     = '0;
         alloc_n    = '0;
         discard_n  = pending_n;
         fetch_pc_n = {RedirectPC[31:2], 2'b00};
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc   <= RESET_PC;
         filled_q   <= '0;
         head       <= '0;
         tail       <= '0;
         fill_ptr   <= '0;
         alloc      <= '0;
         pending    <= '0;
         discard    <= '0;
         ReqValid   <= 1'b0;
         ReqAddr    <= '0;
         InstrValid <= 1'b0;
         InstrD     <= '0;
         PCD        <= '0;
         PCPlus4D   <= '0;
      end else begin
         fetch_pc   <= fetch_pc_n;
         filled_q   <= filled_n;
         head       <= head_n;
         tail       <= tail_n;
         fill_ptr   <= fill_n;
         alloc      <= alloc_n;
         pending    <= pending_n;
         discard    <= discard_n;
         ReqValid   <= (alloc_n < CW'(DEPTH)) && (discard_n == '0);
         ReqAddr    <= fetch_pc_n;
         InstrValid <= filled_n[head_n];
         if (filled_n[head_n]) begin
            InstrD   <= instr_n[head_n];
            PCD      <= pc_n[head_n];
            PCPlus4D <= pc_n[head_n] + 32'd4;
         end
      end
   end

   // Queue payload needs no reset; only the filled bits qualify it
   always_ff @(posedge clk) begin
      pc_q    <= pc_n;
      instr_q <= instr_n;
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: in-order memory model with variable latency,
// stalls, redirects, mid-stream reset, and a second instance exercising PC wrap.
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        ReqValid, ReqReady, RespValid, Redirect, InstrValid, InstrReady;
   logic [31:0] ReqAddr, RespData, RedirectPC, InstrD, PCD, PCPlus4D;

   logic        ReqValid2, ReqReady2, RespValid2, InstrValid2, InstrReady2;
   logic [31:0] ReqAddr2, RespData2, InstrD2, PCD2, PCPlus4D2;

   always #5 clk = ~clk;

   instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqReady(ReqReady),
      .RespValid(RespValid), .RespData(RespData),
      .Redirect(Redirect), .RedirectPC(RedirectPC),
      .InstrValid(InstrValid), .InstrReady(InstrReady),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
   );

   instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .ReqValid(ReqValid2), .ReqAddr(ReqAddr2), .ReqReady(ReqReady2),
      .RespValid(RespValid2), .RespData(RespData2),
      .Redirect(1'b0), .RedirectPC(32'h0),
      .InstrValid(InstrValid2), .InstrReady(InstrReady2),
      .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   mreq_t       mq[$];
   exp_t        sb[$];
   int          tick = 0;
   int          lat  = 1;
   logic [31:0] model_pc = 32'h0;

   // Monitor + scoreboard + memory request capture for the main instance
   always @(posedge clk) begin
      exp_t e;
      tick++;
      if (RespValid && mq.size() > 0) void'(mq.pop_front());
      if (rst) begin
         sb.delete();
         model_pc = 32'h0;
      end else begin
         if (InstrValid && InstrReady) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_instr: got pc %h instr %h, none expected", PCD, InstrD);
            end else begin
               e = sb.pop_front();
               check("instr_d", InstrD, e.instr);
               check("pc_d", PCD, e.pc);
               check("pc_plus4_d", PCPlus4D, e.pc + 32'd4);
            end
         end
         if (ReqValid && ReqReady) begin
            check("req_addr", ReqAddr, model_pc);
            mq.push_back('{addr: ReqAddr, due: tick + lat - 1});
            sb.push_back('{pc: model_pc, instr: model_pc ^ 32'hA5A5_0000});
            model_pc = model_pc + 32'd4;
         end
         if (Redirect) begin
            sb.delete();
            model_pc = {RedirectPC[31:2], 2'b00};
         end
      end
   end

   // In-order memory returning addr ^ A5A5_0000 after lat cycles
   always @(negedge clk) begin
      if (mq.size() > 0 && mq[0].due <= tick) begin
         RespValid = 1'b1;
         RespData  = mq[0].addr ^ 32'hA5A5_0000;
      end else begin
         RespValid = 1'b0;
         RespData  = 32'h0;
      end
   end

   // Wrap instance: 1-cycle memory and table-driven checks of the first three fetches
   logic        f2_fire = 1'b0;
   logic [31:0] f2_addr = 32'h0;
   int          r2 = 0;
   int          x2 = 0;
   logic [31:0] t2_addr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
   logic [31:0] t2_pc4  [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
   logic [31:0] t2_ins  [3] = '{32'h5A5A_FFF8, 32'h5A5A_FFFC, 32'hA5A5_0000};

   always @(posedge clk) begin
      f2_fire = !rst && ReqValid2 && ReqReady2;
      f2_addr = ReqAddr2;
      if (f2_fire && r2 < 3) begin
         check("wrap_req_addr", ReqAddr2, t2_addr[r2]);
         r2++;
      end
      if (!rst && InstrValid2 && InstrReady2 && x2 < 3) begin
         check("wrap_pc_d", PCD2, t2_addr[x2]);
         check("wrap_pc_plus4_d", PCPlus4D2, t2_pc4[x2]);
         check("wrap_instr_d", InstrD2, t2_ins[x2]);
         x2++;
      end
   end

   always @(negedge clk) begin
      RespValid2 = f2_fire;
      RespData2  = f2_addr ^ 32'hA5A5_0000;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int k;
      rst         = 1'b1;
      ReqReady    = 1'b1;
      InstrReady  = 1'b1;
      Redirect    = 1'b0;
      RedirectPC  = 32'h0;
      ReqReady2   = 1'b1;
      InstrReady2 = 1'b1;
      repeat (3) step();

      check("rst_req_valid", ReqValid, 1'b0);
      check("rst_req_addr", ReqAddr, 32'h0);
      check("rst_instr_valid", InstrValid, 1'b0);
      check("rst_instr_d", InstrD, 32'h0);
      check("rst_pc_d", PCD, 32'h0);
      check("rst_pc_plus4_d", PCPlus4D, 32'h0);
      check("rst_wrap_req_valid", ReqValid2, 1'b0);
      check("rst_wrap_req_addr", ReqAddr2, 32'h0);

      rst = 1'b0;
      step();
      check("rel_req_valid", ReqValid, 1'b1);
      check("rel_req_addr", ReqAddr, 32'h0);

      // Stall decode at the very first instruction
      k = 0;
      while (!InstrValid && k < 10) begin step(); k++; end
      check("first_instr_valid", InstrValid, 1'b1);
      check("first_pc_d", PCD, 32'h0);
      InstrReady = 1'b0;
      repeat (6) step();
      check("stall_req_valid", ReqValid, 1'b0);
      check("stall_instr_valid", InstrValid, 1'b1);
      check("stall_pc_d", PCD, 32'h0);
      InstrReady = 1'b1;
      repeat (12) step();

      // Redirect with two old requests outstanding under 3-cycle latency
      lat = 3;
      k = 0;
      while (!(mq.size() == 2 && !RespValid) && k < 40) begin step(); k++; end
      check("redir_setup_outstanding", 32'(mq.size()), 32'd2);
      Redirect   = 1'b1;
      RedirectPC = 32'h0000_0103;
      step();
      Redirect = 1'b0;
      check("redir_req_held", ReqValid, 1'b0);
      k = 0;
      while (!ReqValid && k < 20) begin step(); k++; end
      check("redir_req_valid", ReqValid, 1'b1);
      check("redir_req_addr", ReqAddr, 32'h0000_0100);
      check("redir_old_drained", 32'(mq.size()), 32'd0);
      k = 0;
      while (!InstrValid && k < 20) begin step(); k++; end
      check("redir_first_pc_d", PCD, 32'h0000_0100);
      repeat (6) step();

      // Redirect in a cycle that also has a response and a request fire
      lat = 1;
      k = 0;
      while (!(ReqValid && RespValid) && k < 20) begin step(); k++; end
      check("coinc_setup_resp", RespValid, 1'b1);
      Redirect   = 1'b1;
      RedirectPC = 32'h0000_0200;
      step();
      Redirect = 1'b0;
      check("coinc_req_held", ReqValid, 1'b0);
      k = 0;
      while (!ReqValid && k < 20) begin step(); k++; end
      check("coinc_req_addr", ReqAddr, 32'h0000_0200);
      check("coinc_old_drained", 32'(mq.size()), 32'd0);
      repeat (8) step();

      // Reset mid-stream with a full queue and two requests pending
      lat = 3;
      k = 0;
      while (mq.size() != 2 && k < 40) begin step(); k++; end
      check("mrst_setup_outstanding", 32'(mq.size()), 32'd2);
      rst = 1'b1;
      step();
      check("mrst_req_valid", ReqValid, 1'b0);
      check("mrst_req_addr", ReqAddr, 32'h0);
      check("mrst_instr_valid", InstrValid, 1'b0);
      check("mrst_instr_d", InstrD, 32'h0);
      check("mrst_pc_d", PCD, 32'h0);
      check("mrst_pc_plus4_d", PCPlus4D, 32'h0);
      repeat (4) step();
      check("mrst_stale_drained", 32'(mq.size()), 32'd0);
      check("mrst_still_idle", ReqValid, 1'b0);
      rst = 1'b0;
      lat = 1;
      step();
      check("mrst_rel_req_valid", ReqValid, 1'b1);
      check("mrst_rel_req_addr", ReqAddr, 32'h0);
      repeat (12) step();

      ReqReady = 1'b0;
      repeat (10) step();
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("wrap_req_count", 32'(r2), 32'd3);
      check("wrap_xfer_count", 32'(x2), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
